pulsecap: RTL

- Capture block for the receive side of the 16-parallel-sample AXIS sample stream, e.g. the ADC path or a loopback from the pulse generator.
- On a start condition it skips a programmable number of valid beats, then captures 1 or 2 beats (16 or 32 samples) into a register bank for software readback.
- It flags completion and counts completed captures.
- s_axis tready is always 1; the block never back-pressures.

---
 rtl/pulsecap.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pulsecap.sv
// ---------------------------------------------------------------------------
// pulsecap -- capture block on the receive side of the 16-sample AXIS stream.
//
// When the selected start goes high, the block arms and skips DELAY_REG valid
// beats. It then captures one beat (16 samples, MODE_REG=0) or two beats
// (32 samples, MODE_REG=1) into CAP_DATA, sets DONE_REG and increments
// CAP_CNT_REG. A held start produces exactly one capture. Dropping start
// while waiting or capturing aborts back to idle. The block never applies
// back-pressure.
//
// Build option: PULSECAP_THR_TRIG_EN adds THR_REG and a threshold wait state.
// Delay counting then begins only after the first valid beat that has a
// sample >= THR_REG (signed).
//
// Ports:
//   aclk, aresetn    clock, synchronous active-low reset
//   s_axis_tvalid    input beat valid
//   s_axis_tready    constant 1
//   s_axis_tdata     16 samples per beat, sample k at [16k+:16]
//   start            hardware start, already synchronous to aclk
//   START_REG        software start (asynchronous, synchronised here)
//   START_SRC_REG    start select: 0 = START_REG, 1 = start (asynchronous)
//   MODE_REG         0: capture 16 samples, 1: capture 32 samples
//   DELAY_REG        valid beats to skip before capturing
//   THR_REG          signed trigger threshold (PULSECAP_THR_TRIG_EN only)
//   CAP_DATA         captured samples, sample j at [16j+:16], j = 0..31
//   DONE_REG         capture complete
//   CAP_CNT_REG      completed capture count (wraps)
// ---------------------------------------------------------------------------
module pulsecap #(
    parameter int N = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [16*N-1:0]   s_axis_tdata,
    input  logic              start,
    input  logic              START_REG,
    input  logic              START_SRC_REG,
    input  logic              MODE_REG,
    input  logic [31:0]       DELAY_REG,
`ifdef PULSECAP_THR_TRIG_EN
    input  logic [15:0]       THR_REG,
`endif
    output logic [32*N-1:0]   CAP_DATA,
    output logic              DONE_REG,
    output logic [31:0]       CAP_CNT_REG
);

    typedef enum logic [2:0] {
        IDLE_ST  = 3'd0,
        ARM0_ST  = 3'd1,
        ARM1_ST  = 3'd2,
        DELAY_ST = 3'd3,
        CAP0_ST  = 3'd4,
        CAP1_ST  = 3'd5,
        DONE_ST  = 3'd6
`ifdef PULSECAP_THR_TRIG_EN
        , THR_ST = 3'd7
`endif
    } state_t;

    state_t            state_q, state_d;
    logic              start_reg_meta_q, start_reg_sync_q;
    logic              start_src_meta_q, start_src_sync_q;
    logic              start_mux;
    logic              beat_valid_q;
    logic [16*N-1:0]   beat_data_q;
    logic              mode_r1_q, mode_r2_q;
    logic [31:0]       delay_r1_q, delay_r2_q;
    logic [31:0]       cnt_q, cnt_d;
    logic [32*N-1:0]   cap_data_q, cap_data_d;
    logic              done_q, done_d;
    logic [31:0]       cap_cnt_q, cap_cnt_d;
`ifdef PULSECAP_THR_TRIG_EN
    logic [15:0]       thr_r1_q, thr_r2_q;
    logic              thr_hit;
`endif

    assign s_axis_tready = 1'b1;
    assign start_mux     = start_src_sync_q ? start : start_reg_sync_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values no matter how the statements are ordered.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            start_reg_meta_q <= 1'b0;
            start_reg_sync_q <= 1'b0;
            start_src_meta_q <= 1'b0;
            start_src_sync_q <= 1'b0;
            beat_valid_q     <= 1'b0;
            beat_data_q      <= '0;
            mode_r1_q        <= 1'b0;
            mode_r2_q        <= 1'b0;
            delay_r1_q       <= '0;
            delay_r2_q       <= '0;
`ifdef PULSECAP_THR_TRIG_EN
            thr_r1_q         <= '0;
            thr_r2_q         <= '0;
`endif
            state_q          <= IDLE_ST;
            cnt_q            <= '0;
            // NOTE: the capture bank is reset like any other flop, because
            // software may read CAP_DATA straight after reset. It must not be
            // treated as uninitialised storage.
            cap_data_q       <= '0;
            done_q           <= 1'b0;
            cap_cnt_q        <= '0;
        end else begin
            start_reg_meta_q <= START_REG;
            start_reg_sync_q <= start_reg_meta_q;
            start_src_meta_q <= START_SRC_REG;
            start_src_sync_q <= start_src_meta_q;
            beat_valid_q     <= s_axis_tvalid;
            beat_data_q      <= s_axis_tdata;
            // Software settings are sampled once per arm. The second stage
            // gives the FSM a copy that cannot change mid-capture.
            if (state_q == ARM0_ST) begin
                mode_r1_q  <= MODE_REG;
                delay_r1_q <= DELAY_REG;
`ifdef PULSECAP_THR_TRIG_EN
                thr_r1_q   <= THR_REG;
`endif
            end
            mode_r2_q  <= mode_r1_q;
            delay_r2_q <= delay_r1_q;
`ifdef PULSECAP_THR_TRIG_EN
            thr_r2_q   <= thr_r1_q;
`endif
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_data_q <= cap_data_d;
            done_q     <= done_d;
            cap_cnt_q  <= cap_cnt_d;
        end
    end

`ifdef PULSECAP_THR_TRIG_EN
    // Trigger when any sample of the registered beat reaches the threshold.
    always_comb begin
        thr_hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            if ($signed(beat_data_q[16*k +: 16]) >= $signed(thr_r2_q)) begin
                thr_hit = 1'b1;
            end
        end
    end
`endif

    // NOTE: every _d signal receives its hold/default value first. A path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        cap_data_d = cap_data_q;
        done_d     = done_q;
        cap_cnt_d  = cap_cnt_q;
        case (state_q)
            IDLE_ST: begin
                if (start_mux) state_d = ARM0_ST;
            end
            ARM0_ST: begin
                cap_data_d = '0;
                done_d     = 1'b0;
                state_d    = ARM1_ST;
            end
            ARM1_ST: begin
`ifdef PULSECAP_THR_TRIG_EN
                state_d = THR_ST;
`else
                state_d = DELAY_ST;
`endif
            end
`ifdef PULSECAP_THR_TRIG_EN
            THR_ST: begin
                // The trigger beat itself does not count toward the delay.
                if (!start_mux)                  state_d = IDLE_ST;
                else if (beat_valid_q && thr_hit) state_d = DELAY_ST;
            end
`endif
            DELAY_ST: begin
                // Abort takes priority. The beat present on the exit cycle
                // is dropped.
                if (!start_mux) begin
                    state_d = IDLE_ST;
                end else if (cnt_q == delay_r2_q) begin
                    state_d = CAP0_ST;
                end else begin
                    cnt_d = cnt_q + {31'd0, beat_valid_q};
                end
            end
            CAP0_ST: begin
                if (!start_mux) begin
                    state_d = IDLE_ST;
                end else if (beat_valid_q) begin
                    cap_data_d[16*N-1:0] = beat_data_q;
                    if (mode_r2_q) begin
                        state_d = CAP1_ST;
                    end else begin
                        state_d   = DONE_ST;
                        done_d    = 1'b1;
                        cap_cnt_d = cap_cnt_q + 32'd1;
                    end
                end
            end
            CAP1_ST: begin
                if (!start_mux) begin
                    state_d = IDLE_ST;
                end else if (beat_valid_q) begin
                    cap_data_d[32*N-1:16*N] = beat_data_q;
                    state_d   = DONE_ST;
                    done_d    = 1'b1;
                    cap_cnt_d = cap_cnt_q + 32'd1;
                end
            end
            DONE_ST: begin
                // Hold until start is released, so a held start captures once.
                if (!start_mux) state_d = IDLE_ST;
            end
            default: state_d = IDLE_ST;
        endcase
    end

    assign CAP_DATA    = cap_data_q;
    assign DONE_REG    = done_q;
    assign CAP_CNT_REG = cap_cnt_q;

endmodule
